// File: rtl/xdma_read_meta_manager_pkg.sv
// Shared xDMA read-side types.
//   id_t / len_t       default DMA ID and beat-length types
//   xdma_req_meta_t    per-request metadata queued on issue {dma_id, dma_length}
//   xdma_rd_state_e    read meta manager FSM states (IDLE, BUSY)
package xdma_read_meta_manager_pkg;

    typedef logic [3:0] id_t;
    typedef logic [3:0] len_t;

    typedef struct packed {
        id_t  dma_id;
        len_t dma_length;
    } xdma_req_meta_t;

    typedef enum logic {
        IDLE,
        BUSY
    } xdma_rd_state_e;

endpackage

// File: rtl/counter.sv
// Up counter with synchronous clear (clear has priority over enable).
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         reset count to 0
//   en_i            increment, modulo 2^WIDTH
//   q_o             current count
module counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      q_o <= '0;
        else if (clear_i) q_o <= '0;
        else if (en_i)    q_o <= q_o + 1'b1;
    end

endmodule

// File: rtl/fifo_v3.sv
// Small synchronous FIFO.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   data_i, push_i  write port; a push while full is dropped
//   data_o, pop_i   head of queue; a pop while empty is ignored
//   full_o          occupancy == DEPTH
//   usage_o         occupancy, 0..DEPTH
// With FALL_THROUGH set, an empty FIFO presents data_i on data_o in the
// same cycle and a simultaneous push+pop bypasses storage.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 4,
    localparam int unsigned AddrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  full_o,
    output logic [CntW-1:0]       usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0]      rd_q, wr_q;
    logic [CntW-1:0]       cnt_q;
    logic                  empty, bypass, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign usage_o = cnt_q;
    assign bypass  = FALL_THROUGH && empty && push_i && pop_i;
    assign do_push = push_i && !full_o && !bypass;
    assign do_pop  = pop_i && !empty;
    assign data_o  = (FALL_THROUGH && empty) ? data_i : mem_q[rd_q];

    function automatic logic [AddrW-1:0] next_ptr(input logic [AddrW-1:0] p);
        return (p == AddrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= next_ptr(wr_q);
            end
            if (do_pop) rd_q <= next_ptr(rd_q);
            if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/xdma_read_meta_manager.sv
// xDMA read meta manager: queues {dma_id, dma_length} of issued reads and
// counts R-channel handshakes against the head request, pulsing done with
// the head's ID once all its beats have arrived.
//   read_req_meta_i/valid_i, read_req_ready_o   metadata push (ready = !full)
//   read_happening_i, read_last_i               R handshake and r.last
//   read_req_done_o, done_dma_id_o              registered completion pulse
//   cur_dma_id_o                                head ID while BUSY, else 0
//   outstanding_o                               FIFO occupancy
//   proto_err_o                                 sticky protocol error
// Optional: `define XDMA_READ_META_CHECK_EN adds proto_err_o and its checker;
// without it read_last_i is unused.
module xdma_read_meta_manager #(
    parameter type id_t                      = xdma_read_meta_manager_pkg::id_t,
    parameter type len_t                     = xdma_read_meta_manager_pkg::len_t,
    parameter type xdma_req_meta_t           = xdma_read_meta_manager_pkg::xdma_req_meta_t,
    parameter int unsigned NumOutstanding    = 4,
    parameter int unsigned LenWidth          = $bits(len_t),
    localparam int unsigned CntWidth         = $clog2(NumOutstanding + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [$bits(xdma_req_meta_t)-1:0]  read_req_meta_i,
    input  logic                               read_req_valid_i,
    output logic                               read_req_ready_o,
    input  logic                               read_happening_i,
    input  logic                               read_last_i,
    output logic                               read_req_done_o,
    output logic [$bits(id_t)-1:0]             done_dma_id_o,
    output logic [$bits(id_t)-1:0]             cur_dma_id_o,
    output logic [CntWidth-1:0]                outstanding_o
`ifdef XDMA_READ_META_CHECK_EN
   ,output logic                               proto_err_o
`endif
);

    import xdma_read_meta_manager_pkg::*;

    xdma_rd_state_e                  state_q, state_d;
    logic [$bits(xdma_req_meta_t)-1:0] head_raw;
    xdma_req_meta_t                  head;
    logic                            full, push, pop, busy, zero_len, completing, cnt_en;
    logic [CntWidth-1:0]             usage;
    logic [LenWidth-1:0]             beats_q, beats_inc;
    logic                            done_q;
    logic [$bits(id_t)-1:0]          done_id_q;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   ($bits(xdma_req_meta_t)),
        .DEPTH        (NumOutstanding)
    ) i_meta_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .full_o  (full),
        .usage_o (usage),
        .data_i  (read_req_meta_i),
        .push_i  (push),
        .data_o  (head_raw),
        .pop_i   (pop)
    );

    counter #(
        .WIDTH (LenWidth)
    ) i_beat_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (pop),
        .en_i    (cnt_en),
        .q_o     (beats_q)
    );

    assign head       = head_raw;
    assign busy       = (state_q == BUSY);
    assign push       = read_req_valid_i && !full;
    assign beats_inc  = beats_q + 1'b1;
    assign zero_len   = (head.dma_length == '0);
    assign completing = read_happening_i && (beats_inc == head.dma_length);
    // A zero-length head retires immediately; beats in that cycle are not its own.
    assign pop        = busy && (zero_len || completing);
    assign cnt_en     = busy && read_happening_i && !pop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (push) state_d = BUSY;
            BUSY:    if (pop && !push && (usage == CntWidth'(1))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= pop;
            done_id_q <= pop ? head.dma_id : '0;
        end
    end

    assign read_req_ready_o = !full;
    assign outstanding_o    = usage;
    assign cur_dma_id_o     = busy ? head.dma_id : '0;
    assign read_req_done_o  = done_q;
    assign done_dma_id_o    = done_id_q;

`ifdef XDMA_READ_META_CHECK_EN
    logic err_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if ((read_happening_i && !busy) ||
                     (read_happening_i && busy && !zero_len && (read_last_i != completing))) begin
            err_q <= 1'b1;
        end
    end
    assign proto_err_o = err_q;
`else
    logic unused_read_last;
    assign unused_read_last = read_last_i;
`endif

endmodule

// File: tb/tb_xdma_read_meta_manager.sv
module tb_xdma_read_meta_manager;
    import xdma_read_meta_manager_pkg::*;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    xdma_req_meta_t meta;
    logic           valid, rh, last;
    logic           ready, done, err;
    logic [3:0]     done_id, cur_id;
    logic [2:0]     outst;

    always #5 clk = ~clk;

    xdma_read_meta_manager #(
        .NumOutstanding (N)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .read_req_meta_i  (meta),
        .read_req_valid_i (valid),
        .read_req_ready_o (ready),
        .read_happening_i (rh),
        .read_last_i      (last),
        .read_req_done_o  (done),
        .done_dma_id_o    (done_id),
        .cur_dma_id_o     (cur_id),
        .outstanding_o    (outst)
`ifdef XDMA_READ_META_CHECK_EN
       ,.proto_err_o      (err)
`endif
    );
`ifndef XDMA_READ_META_CHECK_EN
    assign err = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue of requests ----------------
    typedef struct {
        int id;
        int len;
    } ent_t;

    ent_t mq[$];
    int   m_beats   = 0;
    bit   m_done    = 0;
    int   m_done_id = 0;
    bit   m_err     = 0;

    function automatic bit m_completing();
        return (mq.size() > 0) && (mq[0].len != 0) && (m_beats + 1 == mq[0].len);
    endfunction

    task automatic model_step();
        bit   popped = 0;
        int   hid    = 0;
        bit   pushed = valid && (mq.size() < N);
        ent_t e;
        if (mq.size() > 0) begin
            if (rh && mq[0].len != 0 && (last != (m_beats + 1 == mq[0].len))) m_err = 1;
            if (mq[0].len == 0 || (rh && m_beats + 1 == mq[0].len)) begin
                popped  = 1;
                hid     = mq[0].id;
                mq.delete(0);
                m_beats = 0;
            end else if (rh) begin
                m_beats++;
            end
        end else if (rh) begin
            m_err = 1;
        end
        m_done    = popped;
        m_done_id = hid;
        if (pushed) begin
            e.id  = int'(meta.dma_id);
            e.len = int'(meta.dma_length);
            mq.push_back(e);
        end
    endtask

    // Single compare process: model advances on each edge, outputs checked 1 after.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                m_beats   = 0;
                m_done    = 0;
                m_done_id = 0;
                m_err     = 0;
            end else begin
                model_step();
            end
            #1;
            chk("ready",       ready,   (mq.size() < N) ? 1 : 0);
            chk("outstanding", outst,   mq.size());
            chk("cur_id",      cur_id,  (mq.size() > 0) ? mq[0].id : 0);
            chk("done",        done,    m_done);
            chk("done_id",     done_id, m_done_id);
`ifdef XDMA_READ_META_CHECK_EN
            chk("proto_err",   err,     m_err);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        valid = 0;
        rh    = 0;
        last  = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        step();
        step();
        rst_n = 1;
    endtask

    task automatic push(input int id, input int len);
        meta.dma_id     = id_t'(id);
        meta.dma_length = len_t'(len);
        valid = 1;
        step();
        valid = 0;
    endtask

    int exp_done[6] = '{0, 1, 1, 0, 0, 1};
    int exp_id[6]   = '{0, 1, 2, 0, 0, 5};
    int exp_out[6]  = '{3, 2, 1, 1, 1, 0};

    initial begin
        rst_n = 0;
        meta  = '0;
        idle_inputs();
        step();
        step();
        rst_n = 1;
        step();
        chk("rst_ready", ready, 1);
        chk("rst_outst", outst, 0);
        chk("rst_done",  done,  0);
        chk("rst_cur",   cur_id, 0);

        // single request {3,4}
        push(3, 4);
        chk("t1_cur", cur_id, 3);
        chk("t1_outst", outst, 1);
        for (int b = 1; b <= 4; b++) begin
            rh   = 1;
            last = (b == 4);
            step();
            chk("t1_done", done, (b == 4) ? 1 : 0);
        end
        chk("t1_done_id", done_id, 3);
        chk("t1_cur_after", cur_id, 0);
        rh = 0;
        last = 0;
        step();
        chk("t1_pulse_end", done, 0);

        // three queued, six contiguous beats
        push(1, 2);
        push(2, 1);
        push(5, 3);
        for (int b = 0; b < 6; b++) begin
            rh   = 1;
            last = exp_done[b][0];
            step();
            chk("t2_done", done, exp_done[b]);
            chk("t2_done_id", done_id, exp_id[b]);
            chk("t2_outst", outst, exp_out[b]);
        end
        idle_inputs();
        step();

        // full FIFO: push during pop is refused, accepted next cycle
        for (int i = 0; i < 4; i++) push(8 + i, 2);
        chk("t3_ready_full", ready, 0);
        chk("t3_outst_full", outst, 4);
        rh = 1;
        last = 0;
        step();
        last = 1;
        meta.dma_id = 4'd12;
        meta.dma_length = 4'd1;
        valid = 1;
        step();
        chk("t3_outst_pop", outst, 3);
        chk("t3_ready_pop", ready, 1);
        rh = 0;
        last = 0;
        step();
        valid = 0;
        chk("t3_outst_retry", outst, 4);
        for (int i = 0; i < 7; i++) begin
            rh   = 1;
            last = m_completing();
            step();
        end
        idle_inputs();
        step();
        chk("t3_drained", outst, 0);

        // zero-length request
        push(7, 0);
        chk("t4_done_early", done, 0);
        step();
        chk("t4_done", done, 1);
        chk("t4_done_id", done_id, 7);
        step();
        chk("t4_done_end", done, 0);

        // reset mid-transfer
        push(6, 5);
        rh = 1;
        step();
        step();
        rh = 0;
        chk("t5_cur_pre", cur_id, 6);
        rst_n = 0;
        #1;
        chk("t5_rst_outst", outst, 0);
        chk("t5_rst_cur", cur_id, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_done_id", done_id, 0);
        step();
        step();
        rst_n = 1;
        push(4, 1);
        rh = 1;
        last = 1;
        step();
        chk("t5_done", done, 1);
        chk("t5_done_id", done_id, 4);
        idle_inputs();
        step();

`ifdef XDMA_READ_META_CHECK_EN
        chk("t6_err_clear", err, 0);
        push(9, 4);
        rh = 1;
        last = 0;
        step();
        last = 1;
        step();
        chk("t6_err_last", err, 1);
        last = 0;
        step();
        last = 1;
        step();
        idle_inputs();
        step();
        chk("t6_err_sticky", err, 1);
        do_reset();
        chk("t6_err_reset", err, 0);
        rh = 1;
        step();
        rh = 0;
        chk("t6_err_idle_beat", err, 1);
        step();
        chk("t6_err_idle_sticky", err, 1);
        do_reset();
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            valid = ($urandom_range(0, 1) == 1);
            meta.dma_id = id_t'($urandom);
            r = $urandom_range(0, 9);
            if (r < 2)      meta.dma_length = 4'd0;
            else if (r < 8) meta.dma_length = len_t'($urandom_range(1, 4));
            else            meta.dma_length = len_t'($urandom_range(5, 15));
            rh   = ($urandom_range(0, 4) != 0);
            last = rh && m_completing();
            if ($urandom_range(0, 599) == 0) do_reset();
            step();
        end
        idle_inputs();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xdma_read_meta_manager.md
# xdma_read_meta_manager

Read-side counterpart of the write meta manager in the xDMA AXI adapter. It queues metadata (DMA ID, beat length) for issued read requests and counts AXI R-channel handshakes against the request at the queue head. When all beats of a request have arrived, it emits a one-cycle completion pulse with that request's DMA ID. It sits between the read-request issue path and the R-channel data sink and supports up to `NumOutstanding` requests in flight.

## Interface
- `xdma_req_meta_t`, default `logic`: packed struct with fields `dma_id` (`id_t`) and `dma_length` (`len_t`, number of R beats).
- `id_t`, default `logic`: DMA ID type.
- `len_t`, default `logic`: length type.
- `NumOutstanding`, default 4: metadata FIFO depth, ≥1.
- `LenWidth`, default `$bits(len_t)`: dependent parameter, do not override.
- `clk_i`  in  1  clock; the single clock of the block.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `read_req_meta_i`  in  `$bits(xdma_req_meta_t)`  metadata of the newly issued read.
- `read_req_valid_i`  in  1  metadata valid.
- `read_req_ready_o`  out  1  FIFO can accept; equals `!full`.
- `read_happening_i`  in  1  R handshake (`r.valid && r.ready`) this cycle.
- `read_last_i`  in  1  `r.last` of the current beat.
- `read_req_done_o`  out  1  head request complete, one-cycle pulse, registered.
- `done_dma_id_o`  out  `$bits(id_t)`  ID of the completed request; valid with `read_req_done_o`, else `'0`.
- `cur_dma_id_o`  out  `$bits(id_t)`  head ID while BUSY, else `'0`.
- `outstanding_o`  out  `$clog2(NumOutstanding+1)`  FIFO occupancy.
- `proto_err_o`  out  1  sticky protocol error; present only with the macro.

## Operation
- Push happens on `read_req_valid_i && read_req_ready_o`. There is no fall-through: the head is visible the cycle after the push.
- The FSM has two states:
  - IDLE: FIFO empty; beat counter held at 0.
  - BUSY: FIFO non-empty; the head is being served.
- IDLE→BUSY when occupancy becomes non-zero. BUSY→IDLE when the head pops and no entry remains; this accounts for a push in the same cycle.
- Beat counter `beats_q` is `len_t` wide and counts up from 0.
- In BUSY, on `read_happening_i`:
  - If `beats_q + 1 == head.dma_length`: pop the head, clear `beats_q`, and register done for the next cycle.
  - Otherwise increment `beats_q`.
- A head with `dma_length == 0` pops in its first BUSY cycle with no beats and produces a done pulse. R beats in that cycle are not counted against it.
- Back-to-back: after a pop, the next entry becomes head in the following cycle with `beats_q = 0`. A beat in the pop cycle belongs to the popping request only.
- Beats while IDLE are ignored.
- Simultaneous push and pop are both honoured. When full, ready is low even if a pop occurs.
- Reset, including mid-transfer: FIFO emptied, `beats_q = 0`, state IDLE, all outputs 0, `proto_err_o = 0`.

## Timing
- `read_req_ready_o` and `outstanding_o` are combinational from FIFO state.
- `cur_dma_id_o` is combinational from the head and the state.
- `read_req_done_o` and `done_dma_id_o` are registered. They assert exactly 1 cycle after the completing beat (or after the zero-length pop) and last one cycle.
- Back-to-back completions may pulse on consecutive cycles.
- Counter arithmetic is modulo 2^LenWidth. Lengths up to 2^LenWidth−1 are legal.

## Configuration
- `XDMA_READ_META_CHECK_EN` defined: adds the `proto_err_o` port and sticky checking logic. `proto_err_o` sets one cycle after either:
  - a beat in IDLE, or
  - `read_last_i` disagreeing with the completing-beat condition.
  
  It clears only on reset. Counting behaviour is unchanged.
- Undefined: no port and no logic. `read_last_i` is unused.

## Structure
- Shared xDMA package holds `xdma_req_meta_t` and the FSM state enum `xdma_rd_state_e` (IDLE, BUSY).
- Sub-modules:
  - `fifo_v3` for the metadata queue (`FALL_THROUGH = 0`, `DEPTH = NumOutstanding`).
  - `counter` (WIDTH = `LenWidth`, up, clear on pop) for `beats_q`.

## Test plan
- Push {id=3, len=4}, then 4 beats with the last flagged → `read_req_done_o` pulses 1 cycle after beat 4, `done_dma_id_o=3`; `cur_dma_id_o=3` during BUSY, 0 after.
- Push {1,2}, {2,1}, {5,3}, then 6 contiguous beats → done pulses with IDs 1, 2, 5 following beats 2, 3, 6; `outstanding_o` steps 3→2→1→0.
- Fill 4 entries → ready low. Push attempt while a pop occurs in the same cycle → not accepted; the push is accepted on the next cycle.
- Push {7,0} → done pulse with ID 7 two cycles after the push, with no beats.
- Reset asserted after 2 of 5 beats → all outputs 0 immediately. New {4,1} plus 1 beat → done with ID 4.
- With the macro: `read_last_i` on beat 2 of 4, or a beat while IDLE → `proto_err_o` rises 1 cycle later and stays high until reset.
